// File: rtl/psum_accumulator.sv
// Accumulates signed MAC column partial sums over several passes into DEPTH entries, then drains them.
// Output is registered: out_valid rises the cycle after the last beat; stalls hold out_* stable.
module psum_accumulator #(
  parameter int OFMAP_BITWIDTH = 32,
  parameter int ACC_BITWIDTH   = 32,
  parameter int DEPTH          = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      acc_start_in,
  input  logic                      last_pass_in,
  input  logic                      MAC_valid_in,
  input  logic [OFMAP_BITWIDTH-1:0] MAC_data_in,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [ACC_BITWIDTH-1:0]   out_data,
  output logic                      out_last,
  output logic                      busy,
  output logic                      sat_flag,
  output logic                      drop_flag
);

  localparam int AW = ACC_BITWIDTH;
  localparam int OW = OFMAP_BITWIDTH;
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
  localparam logic [AW-1:0] ACC_MAX  = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] ACC_MIN  = {1'b1, {(AW-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state;
  logic [AW-1:0]   acc [DEPTH];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [PW-1:0]   rptr_nxt;
  logic            first_pass;

  logic [AW-1:0]   base;
  logic [AW:0]     data_ext;
  logic [AW:0]     sum;
  logic            ovf;
  logic [AW-1:0]   sat_val;

  // One extra bit of headroom: overflow shows up as the top two sum bits disagreeing.
  always_comb begin
    base     = first_pass ? '0 : acc[wptr];
    data_ext = {{(AW+1-OW){MAC_data_in[OW-1]}}, MAC_data_in};
    sum      = {base[AW-1], base} + data_ext;
    ovf      = sum[AW] ^ sum[AW-1];
    sat_val  = ovf ? (sum[AW] ? ACC_MIN : ACC_MAX) : sum[AW-1:0];
    rptr_nxt = rptr + 1'b1;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wptr       <= '0;
      rptr       <= '0;
      first_pass <= 1'b1;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= '0;
      sat_flag   <= 1'b0;
      drop_flag  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) acc[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (acc_start_in) begin
            state      <= ACCUM;
            wptr       <= '0;
            first_pass <= 1'b1;
            sat_flag   <= 1'b0;
            drop_flag  <= 1'b0;
          end else if (MAC_valid_in) begin
            drop_flag <= 1'b1;
          end
        end
        ACCUM: begin
          if (MAC_valid_in) begin
            acc[wptr] <= sat_val;
            wptr      <= wptr + 1'b1;
            if (ovf) sat_flag <= 1'b1;
            if (wptr == LAST_IDX) begin
              first_pass <= 1'b0;
              if (last_pass_in) begin
                // Entry 0 is already final here since this beat writes entry DEPTH-1.
                state     <= DRAIN;
                rptr      <= '0;
                out_valid <= 1'b1;
                out_data  <= acc[0];
                out_last  <= 1'b0;
              end
            end
          end
        end
        DRAIN: begin
          if (MAC_valid_in) drop_flag <= 1'b1;
          if (out_ready) begin
            if (rptr == LAST_IDX) begin
              state     <= IDLE;
              rptr      <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= '0;
            end else begin
              rptr     <= rptr_nxt;
              out_data <= acc[rptr_nxt];
              out_last <= (rptr_nxt == LAST_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator at DEPTH=4, 32-bit data; expected values are hand-computed.
module tb_psum_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        acc_start_in;
  logic        last_pass_in;
  logic        MAC_valid_in;
  logic [31:0] MAC_data_in;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        sat_flag;
  logic        drop_flag;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  psum_accumulator #(
    .OFMAP_BITWIDTH(32),
    .ACC_BITWIDTH  (32),
    .DEPTH         (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .acc_start_in(acc_start_in),
    .last_pass_in(last_pass_in),
    .MAC_valid_in(MAC_valid_in),
    .MAC_data_in (MAC_data_in),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_last    (out_last),
    .busy        (busy),
    .sat_flag    (sat_flag),
    .drop_flag   (drop_flag)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic start_job();
    acc_start_in = 1'b1;
    @(negedge clk);
    acc_start_in = 1'b0;
  endtask

  task automatic send_pass(input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3,
                           input bit last, input bit gap);
    logic [31:0] d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    for (int i = 0; i < 4; i++) begin
      MAC_valid_in = 1'b1;
      MAC_data_in  = d[i];
      last_pass_in = last && (i == 3);
      @(negedge clk);
      MAC_valid_in = 1'b0;
      last_pass_in = 1'b0;
      if (gap && i != 3) @(negedge clk);
    end
  endtask

  task automatic drain(input logic [31:0] e0, input logic [31:0] e1,
                       input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_valid%0d", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("drain_data%0d", i), out_data, e[i]);
      chk($sformatf("drain_last%0d", i), {31'd0, out_last}, (i == 3) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("after_drain_valid", {31'd0, out_valid}, 32'd0);
    chk("after_drain_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; acc_start_in = 1'b0; last_pass_in = 1'b0;
    MAC_valid_in = 1'b0; MAC_data_in = '0; out_ready = 1'b0;
    @(negedge clk);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sat", {31'd0, sat_flag}, 32'd0);
    chk("rst_drop", {31'd0, drop_flag}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single pass.
    start_job();
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_accum_valid", {31'd0, out_valid}, 32'd0);
    send_pass(32'd1, 32'd2, 32'd3, 32'd4, 1'b1, 1'b0);
    drain(32'd1, 32'd2, 32'd3, 32'd4);
    chk("t1_sat", {31'd0, sat_flag}, 32'd0);

    // Beat while idle is dropped and flagged; next start clears it.
    MAC_valid_in = 1'b1; MAC_data_in = 32'd77;
    @(negedge clk);
    MAC_valid_in = 1'b0;
    chk("idle_drop", {31'd0, drop_flag}, 32'd1);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Three passes with non-contiguous beats on the middle one.
    start_job();
    chk("t2_drop_clr", {31'd0, drop_flag}, 32'd0);
    send_pass(32'd10, -32'sd20, 32'd30, -32'sd40, 1'b0, 1'b0);
    send_pass(32'd10, -32'sd20, 32'd30, -32'sd40, 1'b0, 1'b1);
    send_pass(32'd10, -32'sd20, 32'd30, -32'sd40, 1'b1, 1'b0);
    drain(32'd30, -32'sd60, 32'd90, -32'sd120);

    // Positive and negative saturation.
    start_job();
    send_pass(32'h7FFF_FFF0, 32'h8000_0010, 32'd5, 32'd0, 1'b0, 1'b0);
    chk("t3_sat_pass1", {31'd0, sat_flag}, 32'd0);
    send_pass(32'h0000_0020, 32'hFFFF_FFE0, 32'd6, 32'd0, 1'b1, 1'b0);
    chk("t3_sat_drain", {31'd0, sat_flag}, 32'd1);
    drain(32'h7FFF_FFFF, 32'h8000_0000, 32'd11, 32'd0);
    chk("t3_sat_idle", {31'd0, sat_flag}, 32'd1);

    // Stall in DRAIN with stray beats and a stray start.
    start_job();
    chk("t4_sat_clr", {31'd0, sat_flag}, 32'd0);
    send_pass(32'd7, 32'd8, 32'd9, 32'd10, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      MAC_valid_in = 1'b1; MAC_data_in = 32'd99;
      acc_start_in = (i == 2);
      chk($sformatf("stall_valid%0d", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("stall_data%0d", i), out_data, 32'd7);
      chk($sformatf("stall_last%0d", i), {31'd0, out_last}, 32'd0);
      @(negedge clk);
    end
    MAC_valid_in = 1'b0; acc_start_in = 1'b0;
    chk("t4_drop", {31'd0, drop_flag}, 32'd1);
    drain(32'd7, 32'd8, 32'd9, 32'd10);
    chk("t4_drop_idle", {31'd0, drop_flag}, 32'd1);

    // Reset mid-ACCUM abandons the job.
    start_job();
    MAC_valid_in = 1'b1; MAC_data_in = 32'd100;
    @(negedge clk);
    MAC_data_in = 32'd200;
    @(negedge clk);
    MAC_valid_in = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_rst_data", out_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_idle_valid", {31'd0, out_valid}, 32'd0);
    start_job();
    send_pass(32'd5, 32'd6, 32'd7, 32'd8, 1'b1, 1'b1);
    drain(32'd5, 32'd6, 32'd7, 32'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
